// File: rtl/buzzer_pkg.sv
// buzzer_pkg: types and default tone timing shared by the buzzer driver and
// the receive-side tone detector.
package buzzer_pkg;

  // Default half-periods in clock cycles; the driver toggles its output at
  // these spacings, so the detector uses the same numbers as nominal values.
  localparam int ANSWER_HALF_DEFAULT   = 95420;
  localparam int TIMEOVER_HALF_DEFAULT = 50608;

  // Classification of one measured half-period.
  typedef enum logic [1:0] {
    TONE_NONE = 2'd0,
    TONE_A    = 2'd1,
    TONE_T    = 2'd2
  } tone_class_e;

  // Detector lock state.
  typedef enum logic [1:0] {
    ST_SILENT  = 2'd0,
    ST_ARMED   = 2'd1,
    ST_ACQUIRE = 2'd2,
    ST_LOCKED  = 2'd3
  } det_state_e;

endpackage

// File: rtl/buzzer_edge_sync.sv
// buzzer_edge_sync: brings the asynchronous buzzer line into the clock domain
// and produces a registered one-cycle pulse for every transition.
module buzzer_edge_sync (
  input  logic CLK,
  input  logic RST,
  input  logic line,
  output logic edge_event
);

  logic sync1;
  logic sync2;
  logic delayed;

  // Two-flop synchronizer and delay flop reset to the idle-high level, so a
  // quiet line after reset produces no edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      delayed    <= 1'b1;
      edge_event <= 1'b0;
    end else begin
      sync1      <= line;
      sync2      <= sync1;
      delayed    <= sync2;
      edge_event <= (sync2 != delayed);
    end
  end

endmodule

// File: rtl/buzzer_tone_detector.sv
// buzzer_tone_detector: measures the spacing between buzzer-line edges,
// classifies each spacing as Answer, TimeOver or neither, and reports a tone
// once enough consecutive half-periods agree.
module buzzer_tone_detector
  import buzzer_pkg::*;
#(
  parameter int ANSWER_HALF   = ANSWER_HALF_DEFAULT,
  parameter int TIMEOVER_HALF = TIMEOVER_HALF_DEFAULT,
  parameter int TOL           = 1024,
  parameter int CONFIRM       = 4,
  parameter int IDLE_TIMEOUT  = 200000,
  parameter int CW            = 23
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          Buzzer_In,
  output logic          Tone_Answer,
  output logic          Tone_TimeOver,
  output logic          Tone_Valid,
  output logic [CW-1:0] Half_Period
);

  localparam int MW = $clog2(CONFIRM + 1);

  // Acceptance windows, one bit wider than the measurement so HALF+TOL
  // cannot wrap.
  localparam logic [CW:0] A_LO = (CW+1)'(ANSWER_HALF - TOL);
  localparam logic [CW:0] A_HI = (CW+1)'(ANSWER_HALF + TOL);
  localparam logic [CW:0] T_LO = (CW+1)'(TIMEOVER_HALF - TOL);
  localparam logic [CW:0] T_HI = (CW+1)'(TIMEOVER_HALF + TOL);

  localparam logic [CW-1:0] COUNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_TIMEOUT - 1);
  localparam logic [MW-1:0] CONFIRM_M = MW'(CONFIRM);

  // Overlapping windows would make a spacing ambiguous between the two tones.
  if ((ANSWER_HALF - TOL <= TIMEOVER_HALF + TOL) &&
      (TIMEOVER_HALF - TOL <= ANSWER_HALF + TOL)) begin : g_band_overlap
    $error("buzzer_tone_detector: Answer and TimeOver acceptance bands overlap");
  end

  logic          edge_event;
  logic [CW-1:0] count;
  logic [CW-1:0] meas;
  logic [CW:0]   meas_ext;
  logic          timeout_hit;
  tone_class_e   cls;
  tone_class_e   cand;
  tone_class_e   cand_n;
  det_state_e    state;
  det_state_e    state_n;
  logic [MW-1:0] match;
  logic [MW-1:0] match_n;

  buzzer_edge_sync u_edge_sync (
    .CLK        (CLK),
    .RST        (RST),
    .line       (Buzzer_In),
    .edge_event (edge_event)
  );

  // The spacing includes the edge cycle itself; a saturated counter reports
  // the saturated value so it can never match a tone window.
  assign meas        = (count == COUNT_MAX) ? COUNT_MAX : count + CW'(1);
  assign meas_ext    = {1'b0, meas};
  assign timeout_hit = (count == IDLE_LAST);

  // Cycle counter since the last edge, saturating during long silence.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (edge_event) begin
      count <= '0;
    end else if (count != COUNT_MAX) begin
      count <= count + CW'(1);
    end
  end

  // Latest measured spacing, loaded on every edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Half_Period <= '0;
    end else if (edge_event) begin
      Half_Period <= meas;
    end
  end

  // Window comparison of the current measurement.
  always_comb begin
    cls = TONE_NONE;
    if ((meas_ext >= A_LO) && (meas_ext <= A_HI)) begin
      cls = TONE_A;
    end else if ((meas_ext >= T_LO) && (meas_ext <= T_HI)) begin
      cls = TONE_T;
    end
  end

  // State, candidate tone and match count registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_SILENT;
      cand  <= TONE_NONE;
      match <= '0;
    end else begin
      state <= state_n;
      cand  <= cand_n;
      match <= match_n;
    end
  end

  // Lock sequencing: an edge always beats a timeout on the same cycle, and
  // the first edge out of silence only arms since its spacing is meaningless.
  always_comb begin
    state_n = state;
    cand_n  = cand;
    match_n = match;
    if (edge_event) begin
      if (state == ST_SILENT) begin
        state_n = ST_ARMED;
      end else if ((state == ST_LOCKED) && (cls == cand)) begin
        state_n = ST_LOCKED;
      end else begin
        if (cls == TONE_NONE) begin
          match_n = '0;
        end else if (cls == cand) begin
          match_n = match + MW'(1);
        end else begin
          cand_n  = cls;
          match_n = MW'(1);
        end
        if ((state != ST_LOCKED) && (match_n == CONFIRM_M)) begin
          state_n = ST_LOCKED;
        end else begin
          state_n = ST_ACQUIRE;
        end
      end
    end else if ((state != ST_SILENT) && timeout_hit) begin
      state_n = ST_SILENT;
      match_n = '0;
    end
  end

  // Registered tone flags, taken from the next state so they move with it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Tone_Answer   <= 1'b0;
      Tone_TimeOver <= 1'b0;
      Tone_Valid    <= 1'b0;
    end else begin
      Tone_Answer   <= (state_n == ST_LOCKED) && (cand_n == TONE_A);
      Tone_TimeOver <= (state_n == ST_LOCKED) && (cand_n == TONE_T);
      Tone_Valid    <= (state_n == ST_LOCKED) &&
                       ((cand_n == TONE_A) || (cand_n == TONE_T));
    end
  end

endmodule

// File: tb/tb_buzzer_tone_detector.sv
// tb_buzzer_tone_detector: directed bench for the buzzer tone detector with
// scaled-down timing. IDLE_TIMEOUT is set to the upper edge of the Answer
// window so that a +TOL spacing lands exactly on the timeout cycle.
module tb_buzzer_tone_detector;

  localparam int ANS  = 200;
  localparam int TOV  = 100;
  localparam int TOL  = 8;
  localparam int CONF = 4;
  localparam int IDLE = 208;
  localparam int CW   = 10;
  localparam int SAT  = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          Buzzer_In = 1'b1;
  logic          Tone_Answer;
  logic          Tone_TimeOver;
  logic          Tone_Valid;
  logic [CW-1:0] Half_Period;

  int errors = 0;
  int checks = 0;
  bit compareOn = 1'b0;

  buzzer_tone_detector #(
    .ANSWER_HALF   (ANS),
    .TIMEOVER_HALF (TOV),
    .TOL           (TOL),
    .CONFIRM       (CONF),
    .IDLE_TIMEOUT  (IDLE),
    .CW            (CW)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .Buzzer_In     (Buzzer_In),
    .Tone_Answer   (Tone_Answer),
    .Tone_TimeOver (Tone_TimeOver),
    .Tone_Valid    (Tone_Valid),
    .Half_Period   (Half_Period)
  );

  always #5 CLK = ~CLK;

  // Behavioural model: tracks the run of consecutive same-class spacings
  // since the line left silence; a tone is locked while that run is at
  // least CONF long. Edges take effect 3 cycles after they are sampled.
  int   cyc = 0;
  int   pend[$];
  logic lastLevel = 1'b1;
  int   lastEdge = 0;
  bit   mSilent = 1'b1;
  int   runLen = 0;
  int   runClass = 0;
  int   mHalf = 0;
  int   mMeas;
  int   mCls;
  logic expAns = 1'b0;
  logic expTo = 1'b0;
  logic expValid = 1'b0;

  function automatic int classify(input int m);
    int dA;
    int dT;
    dA = (m > ANS) ? (m - ANS) : (ANS - m);
    dT = (m > TOV) ? (m - TOV) : (TOV - m);
    if (dA <= TOL) return 1;
    if (dT <= TOL) return 2;
    return 0;
  endfunction

  always @(posedge CLK) begin
    cyc++;
    if (RST) begin
      pend.delete();
      lastLevel = 1'b1;
      lastEdge  = cyc;
      mSilent   = 1'b1;
      runLen    = 0;
      runClass  = 0;
      mHalf     = 0;
    end else begin
      if (pend.size() > 0 && pend[0] == cyc) begin
        void'(pend.pop_front());
        mMeas = cyc - lastEdge;
        if (mMeas > SAT) mMeas = SAT;
        lastEdge = cyc;
        mHalf    = mMeas;
        if (mSilent) begin
          mSilent = 1'b0;
          runLen  = 0;
        end else begin
          mCls = classify(mMeas);
          if (mCls == 0) begin
            runLen = 0;
          end else if (mCls == runClass && runLen > 0) begin
            runLen++;
          end else begin
            runClass = mCls;
            runLen   = 1;
          end
        end
      end else if (!mSilent && (cyc - lastEdge) == IDLE) begin
        mSilent = 1'b1;
        runLen  = 0;
      end
      if (Buzzer_In !== lastLevel) begin
        pend.push_back(cyc + 3);
        lastLevel = Buzzer_In;
      end
    end
    expAns   = !mSilent && runLen >= CONF && runClass == 1;
    expTo    = !mSilent && runLen >= CONF && runClass == 2;
    expValid = expAns | expTo;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge CLK) begin
    if (compareOn) begin
      checks++;
      if (Tone_Answer !== expAns || Tone_TimeOver !== expTo ||
          Tone_Valid !== expValid || Half_Period !== CW'(mHalf)) begin
        errors++;
        $display("[TB] FAIL model_cycle%0d: got ans=%b to=%b valid=%b half=%0d, expected ans=%b to=%b valid=%b half=%0d",
                 cyc, Tone_Answer, Tone_TimeOver, Tone_Valid, Half_Period,
                 expAns, expTo, expValid, mHalf);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic toggleLine();
    Buzzer_In = ~Buzzer_In;
  endtask

  // Toggle the line `count` times, each toggle followed by `spacing` cycles.
  task automatic applyStimulus(input int spacing, input int count);
    for (int i = 0; i < count; i++) begin
      toggleLine();
      waitCycles(spacing);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    waitCycles(3);
    RST = 1'b0;
    compareOn = 1'b1;
    checkOutput("reset Tone_Answer", Tone_Answer, 0);
    checkOutput("reset Tone_TimeOver", Tone_TimeOver, 0);
    checkOutput("reset Tone_Valid", Tone_Valid, 0);
    checkOutput("reset Half_Period", Half_Period, 0);
    waitCycles(20);

    // Answer lock: five edges at ANS, tone appears three cycles after the 5th
    applyStimulus(ANS, 4);
    toggleLine();
    waitCycles(3);
    checkOutput("answer not yet locked", Tone_Answer, 0);
    waitCycles(1);
    checkOutput("answer locked", Tone_Answer, 1);
    checkOutput("answer valid", Tone_Valid, 1);
    checkOutput("answer half", Half_Period, 200);
    checkOutput("model answer locked", expAns, 1);
    waitCycles(IDLE + 100);
    checkOutput("answer silent after idle", Tone_Valid, 0);

    // TimeOver lock
    applyStimulus(TOV, 4);
    toggleLine();
    waitCycles(4);
    checkOutput("timeover locked", Tone_TimeOver, 1);
    checkOutput("timeover answer low", Tone_Answer, 0);
    checkOutput("timeover half", Half_Period, 100);
    checkOutput("model timeover locked", expTo, 1);
    waitCycles(IDLE + 100);

    // Upper tolerance edge (+TOL, also the exact timeout cycle) locks
    applyStimulus(ANS + TOL, 4);
    toggleLine();
    waitCycles(4);
    checkOutput("plus tol locked", Tone_Answer, 1);
    checkOutput("plus tol half", Half_Period, 208);
    waitCycles(IDLE + 100);

    // +TOL+1 never locks
    applyStimulus(ANS + TOL + 1, 5);
    toggleLine();
    waitCycles(4);
    checkOutput("plus tol+1 not locked", Tone_Valid, 0);
    checkOutput("plus tol+1 half", Half_Period, 209);
    checkOutput("model plus tol+1", expValid, 0);
    waitCycles(IDLE + 100);

    // Lower tolerance edge locks, one below does not
    applyStimulus(ANS - TOL, 4);
    toggleLine();
    waitCycles(4);
    checkOutput("minus tol locked", Tone_Answer, 1);
    waitCycles(IDLE + 100);
    applyStimulus(ANS - TOL - 1, 5);
    toggleLine();
    waitCycles(4);
    checkOutput("minus tol-1 not locked", Tone_Valid, 0);
    checkOutput("minus tol-1 half", Half_Period, 191);
    waitCycles(IDLE + 100);

    // Edge on the timeout cycle keeps the lock; then silence drops it
    applyStimulus(ANS, 4);
    toggleLine();
    waitCycles(IDLE);
    toggleLine();
    waitCycles(4);
    checkOutput("edge at timeout keeps lock", Tone_Answer, 1);
    checkOutput("edge at timeout half", Half_Period, 208);
    waitCycles(207);
    checkOutput("lock held before timeout", Tone_Answer, 1);
    waitCycles(1);
    checkOutput("lock dropped at timeout", Tone_Answer, 0);
    checkOutput("valid dropped at timeout", Tone_Valid, 0);
    checkOutput("model dropped at timeout", expAns, 0);
    waitCycles(IDLE + 100);

    // Switch from Answer to TimeOver spacing
    applyStimulus(ANS, 4);
    toggleLine();
    waitCycles(TOV);
    toggleLine();
    waitCycles(4);
    checkOutput("switch answer dropped", Tone_Answer, 0);
    checkOutput("switch timeover not yet", Tone_TimeOver, 0);
    checkOutput("switch half", Half_Period, 100);
    waitCycles(TOV - 4);
    applyStimulus(TOV, 2);
    toggleLine();
    waitCycles(3);
    checkOutput("switch timeover pending", Tone_TimeOver, 0);
    waitCycles(1);
    checkOutput("switch timeover locked", Tone_TimeOver, 1);
    waitCycles(IDLE + 100);

    // Reset mid-lock with the line at its idle level, then relock
    if (Buzzer_In !== 1'b1) begin
      toggleLine();
      waitCycles(IDLE + 100);
    end
    applyStimulus(ANS, 5);
    toggleLine();
    waitCycles(4);
    checkOutput("pre-reset locked", Tone_Answer, 1);
    waitCycles(46);
    RST = 1'b1;
    waitCycles(1);
    RST = 1'b0;
    checkOutput("reset drops answer", Tone_Answer, 0);
    checkOutput("reset drops valid", Tone_Valid, 0);
    checkOutput("reset clears half", Half_Period, 0);
    waitCycles(149);
    applyStimulus(ANS, 3);
    toggleLine();
    waitCycles(4);
    checkOutput("relock after 4 edges", Tone_Valid, 0);
    waitCycles(ANS - 4);
    toggleLine();
    waitCycles(3);
    checkOutput("relock pending", Tone_Answer, 0);
    waitCycles(1);
    checkOutput("relock after 5 edges", Tone_Answer, 1);
    waitCycles(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
